// File: rtl/motor_cmd_arbiter.sv
// Two-port motion command arbiter with slew limiting, e-stop and command watchdog.
// Port 0 (manual) has priority and locks out port 1 for LOCKOUT_TICKS ramp ticks.
// Optional feature macro: MOTOR_WATCHDOG_EN builds the command-timeout watchdog.
module motor_cmd_arbiter #(
  parameter int unsigned RAMP_DIV      = 98304,
  parameter int unsigned RAMP_STEP     = 4,
  parameter int unsigned TIMEOUT_TICKS = 250,
  parameter int unsigned LOCKOUT_TICKS = 500
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              estop_in,
  input  logic              req0_valid,
  input  logic signed [7:0] req0_left,
  input  logic signed [7:0] req0_right,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic signed [7:0] req1_left,
  input  logic signed [7:0] req1_right,
  output logic              req1_ready,
  output logic signed [7:0] speed_left,
  output logic signed [7:0] speed_right,
  output logic              grant_out,
  output logic              busy_out,
  output logic              timeout_out
);

  localparam int unsigned DivW  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned LockW = (LOCKOUT_TICKS > 0) ? $clog2(LOCKOUT_TICKS + 1) : 1;
  localparam logic signed [8:0] Step9 = 9'(RAMP_STEP);

  typedef enum logic [1:0] {StIdle, StRamp, StHold, StEstop} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   presc_q, presc_d;
  logic [LockW-1:0]  lock_q, lock_d;
  logic signed [7:0] speed_l_q, speed_l_d, speed_r_q, speed_r_d;
  logic signed [7:0] tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic              grant_q, grant_d;
  logic              tick, acc0, acc1, accept, wd_fire;

  // One slew step from s toward t, evaluated in 9 bits so the difference never wraps.
  function automatic logic signed [7:0] ramp_to(input logic signed [7:0] s,
                                                input logic signed [7:0] t);
    logic signed [8:0] s9, t9, diff, nxt;
    s9   = {s[7], s};
    t9   = {t[7], t};
    diff = t9 - s9;
    if (diff > Step9) begin
      nxt = s9 + Step9;
    end else if (diff < -Step9) begin
      nxt = s9 - Step9;
    end else begin
      nxt = t9;
    end
    return nxt[7:0];
  endfunction

  // -128 has no positive mirror, so targets are kept symmetric at +/-127.
  function automatic logic signed [7:0] clamp(input logic signed [7:0] v);
    return (v == 8'sh80) ? 8'sh81 : v;
  endfunction

  assign tick   = (presc_q == DivW'(RAMP_DIV - 1));
  assign acc0   = req0_valid && req0_ready;
  assign acc1   = req1_valid && req1_ready;
  assign accept = acc0 || acc1;

`ifdef MOTOR_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_TICKS + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;

  // Watchdog next state: count ticks since the last accept, fire once on reaching the limit.
  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    wd_fire   = 1'b0;
    if (tick && (wd_q != WdW'(TIMEOUT_TICKS))) begin
      wd_d = wd_q + WdW'(1);
    end
    if (tick && !accept && !estop_in && (wd_q == WdW'(TIMEOUT_TICKS - 1))) begin
      wd_fire   = 1'b1;
      timeout_d = 1'b1;
    end
    if (accept) begin
      wd_d      = '0;
      timeout_d = 1'b0;
    end
    if (estop_in) begin
      wd_d = '0;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_out = timeout_q;
`else
  // Keeps the watchdog parameter referenced when the feature is compiled out.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_TICKS;
  assign wd_fire     = 1'b0;
  assign timeout_out = 1'b0;
`endif

  // Datapath next state: prescaler, slew ramp, lockout, target loading and e-stop override.
  always_comb begin
    presc_d   = tick ? '0 : presc_q + DivW'(1);
    speed_l_d = speed_l_q;
    speed_r_d = speed_r_q;
    tgt_l_d   = tgt_l_q;
    tgt_r_d   = tgt_r_q;
    grant_d   = grant_q;
    lock_d    = lock_q;
    if (tick) begin
      speed_l_d = ramp_to(speed_l_q, tgt_l_q);
      speed_r_d = ramp_to(speed_r_q, tgt_r_q);
      if (lock_q != '0) begin
        lock_d = lock_q - LockW'(1);
      end
    end
    if (wd_fire) begin
      tgt_l_d = '0;
      tgt_r_d = '0;
    end
    if (accept) begin
      tgt_l_d = clamp(acc0 ? req0_left : req1_left);
      tgt_r_d = clamp(acc0 ? req0_right : req1_right);
      grant_d = acc1;
    end
    if (acc0) begin
      lock_d = LockW'(LOCKOUT_TICKS);
    end
    if (estop_in) begin
      speed_l_d = '0;
      speed_r_d = '0;
      tgt_l_d   = '0;
      tgt_r_d   = '0;
      lock_d    = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      presc_q   <= '0;
      speed_l_q <= '0;
      speed_r_q <= '0;
      tgt_l_q   <= '0;
      tgt_r_q   <= '0;
      grant_q   <= 1'b0;
      lock_q    <= '0;
    end else begin
      presc_q   <= presc_d;
      speed_l_q <= speed_l_d;
      speed_r_q <= speed_r_d;
      tgt_l_q   <= tgt_l_d;
      tgt_r_q   <= tgt_r_d;
      grant_q   <= grant_d;
      lock_q    <= lock_d;
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows the next speed/target values so the state always matches the registers.
  always_comb begin
    state_d = state_q;
    if (estop_in) begin
      state_d = StEstop;
    end else if (state_q == StEstop) begin
      state_d = StIdle;
    end else if ((speed_l_d != tgt_l_d) || (speed_r_d != tgt_r_d)) begin
      state_d = StRamp;
    end else if ((tgt_l_d == '0) && (tgt_r_d == '0)) begin
      state_d = StIdle;
    end else begin
      state_d = StHold;
    end
  end

  // Outputs: handshakes from registered state plus current valids.
  always_comb begin
    req0_ready = !estop_in && (state_q != StEstop);
    req1_ready = req0_ready && !req0_valid && (lock_q == '0);
    busy_out   = (state_q == StRamp);
  end

  assign speed_left  = speed_l_q;
  assign speed_right = speed_r_q;
  assign grant_out   = grant_q;

endmodule

// File: tb/tb_motor_cmd_arbiter.sv
// Directed bench for motor_cmd_arbiter with RAMP_DIV=4, RAMP_STEP=4, TIMEOUT_TICKS=5,
// LOCKOUT_TICKS=3. Watchdog expectations follow MOTOR_WATCHDOG_EN.
module tb_motor_cmd_arbiter;

  localparam int unsigned Div  = 4;
  localparam int unsigned Step = 4;
  localparam int unsigned Tmo  = 5;
  localparam int unsigned Lock = 3;

  logic              clk_in     = 1'b0;
  logic              rst_n_in   = 1'b0;
  logic              estop_in   = 1'b0;
  logic              req0_valid = 1'b0;
  logic signed [7:0] req0_left  = '0;
  logic signed [7:0] req0_right = '0;
  logic              req1_valid = 1'b0;
  logic signed [7:0] req1_left  = '0;
  logic signed [7:0] req1_right = '0;
  logic              req0_ready, req1_ready;
  logic signed [7:0] speed_left, speed_right;
  logic              grant_out, busy_out, timeout_out;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned presc    = 0;
  bit          tick_e   = 1'b0;

  motor_cmd_arbiter #(
    .RAMP_DIV      (Div),
    .RAMP_STEP     (Step),
    .TIMEOUT_TICKS (Tmo),
    .LOCKOUT_TICKS (Lock)
  ) u_dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .estop_in    (estop_in),
    .req0_valid  (req0_valid),
    .req0_left   (req0_left),
    .req0_right  (req0_right),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_left   (req1_left),
    .req1_right  (req1_right),
    .req1_ready  (req1_ready),
    .speed_left  (speed_left),
    .speed_right (speed_right),
    .grant_out   (grant_out),
    .busy_out    (busy_out),
    .timeout_out (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_speeds(input string tag, input int l, input int r);
    check_val({tag, "_left"}, speed_left, l);
    check_val({tag, "_right"}, speed_right, r);
  endtask

  // One clock; tick_e tells whether that edge was a ramp tick.
  task automatic cyc();
    @(posedge clk_in);
    tick_e = (presc == Div - 1);
    presc  = (presc + 1) % Div;
    #1;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < Div; i++) begin
      cyc();
      if (tick_e) break;
    end
  endtask

  task automatic send0(input logic signed [7:0] l, input logic signed [7:0] r);
    req0_left = l; req0_right = r; req0_valid = 1'b1;
    cyc();
    req0_valid = 1'b0;
  endtask

  task automatic send1(input logic signed [7:0] l, input logic signed [7:0] r);
    req1_left = l; req1_right = r; req1_valid = 1'b1;
    cyc();
    req1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit done;

    // Reset values
    @(posedge clk_in);
    #2;
    check_speeds("rst", 0, 0);
    check_val("rst_grant", grant_out, 0);
    check_val("rst_timeout", timeout_out, 0);
    check_val("rst_busy", busy_out, 0);
    check_val("rst_ready0", req0_ready, 1);
    check_val("rst_ready1", req1_ready, 1);
    rst_n_in = 1'b1;
    presc    = 0;

    // Port 1 ramp from idle
    send1(8'sd10, -8'sd10);
    check_val("p1_grant", grant_out, 1);
    check_val("p1_busy0", busy_out, 1);
    check_speeds("p1_t0", 0, 0);
    wait_tick();
    check_speeds("p1_t1", 4, -4);
    check_val("p1_busy1", busy_out, 1);
    wait_tick();
    check_speeds("p1_t2", 8, -8);
    wait_tick();
    check_speeds("p1_t3", 10, -10);
    check_val("p1_hold_busy", busy_out, 0);

    // Simultaneous valids, then lockout of port 1
    req0_left = 8'sd20; req0_right = 8'sd20; req0_valid = 1'b1;
    req1_left = -8'sd20; req1_right = -8'sd20; req1_valid = 1'b1;
    #1;
    check_val("both_ready0", req0_ready, 1);
    check_val("both_ready1", req1_ready, 0);
    cyc();
    req0_valid = 1'b0;
    #1;
    check_val("both_grant", grant_out, 0);
    check_val("lock_ready_t0", req1_ready, 0);
    for (int k = 1; k <= 3; k++) begin
      wait_tick();
      check_val($sformatf("lock_ready_t%0d", k), req1_ready, (k == 3) ? 1 : 0);
    end
    check_speeds("both_ramp", 20, 2);
    cyc();
    req1_valid = 1'b0;
    check_val("lock_p1_grant", grant_out, 1);

    // Hold at (8,8), then stale commands
    send0(8'sd8, 8'sd8);
    repeat (3) wait_tick();
    check_speeds("hold8", 8, 8);
    check_val("hold8_busy", busy_out, 0);
    check_val("hold8_timeout", timeout_out, 0);
`ifdef MOTOR_WATCHDOG_EN
    wait_tick();
    check_val("wd_t4_timeout", timeout_out, 0);
    wait_tick();
    check_val("wd_t5_timeout", timeout_out, 1);
    check_val("wd_t5_busy", busy_out, 1);
    check_speeds("wd_t5", 8, 8);
    wait_tick();
    check_speeds("wd_t6", 4, 4);
    wait_tick();
    check_speeds("wd_t7", 0, 0);
    check_val("wd_t7_busy", busy_out, 0);
    check_val("wd_t7_timeout", timeout_out, 1);
`else
    repeat (20) wait_tick();
    check_val("nowd_timeout", timeout_out, 0);
    check_speeds("nowd_hold", 8, 8);
    check_val("nowd_busy", busy_out, 0);
`endif

    // Ramp to (40,-40) with port 0 held, then e-stop
    req0_left = 8'sd40; req0_right = -8'sd40; req0_valid = 1'b1;
    cyc();
    check_val("accept_clears_timeout", timeout_out, 0);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      wait_tick();
      done = (speed_left == 40) && (speed_right == -40);
    end
    check_val("ramp40_reached", int'(done), 1);
    req0_valid = 1'b0;
    estop_in   = 1'b1;
    #1;
    check_val("estop_ready0", req0_ready, 0);
    check_val("estop_ready1", req1_ready, 0);
    check_speeds("estop_pre", 40, -40);
    cyc();
    check_speeds("estop_edge", 0, 0);
    check_val("estop_busy", busy_out, 0);
    repeat (3) cyc();
    check_val("estop_hold_ready0", req0_ready, 0);
    check_speeds("estop_hold", 0, 0);
    estop_in = 1'b0;
    #1;
    check_val("estop_exit_ready0", req0_ready, 0);
    cyc();
    check_val("estop_idle_ready0", req0_ready, 1);
    check_val("estop_idle_ready1", req1_ready, 1);
    check_speeds("estop_idle", 0, 0);

    // -128 clamps to -127
    req0_left = -8'sd128; req0_right = 8'sd127; req0_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      wait_tick();
      done = (speed_left == -127) && (speed_right == 127);
    end
    check_val("clamp_reached", int'(done), 1);
    repeat (2) wait_tick();
    check_speeds("clamp_settled", -127, 127);
    check_val("clamp_busy", busy_out, 0);
    req0_valid = 1'b0;

    // Reset mid-ramp
    repeat (3) wait_tick();
    send1(8'sd100, -8'sd100);
    check_val("mid_grant", grant_out, 1);
    repeat (2) wait_tick();
    check_speeds("mid_ramp", -119, 119);
    check_val("mid_busy", busy_out, 1);
    #3;
    rst_n_in = 1'b0;
    #1;
    check_speeds("async_rst", 0, 0);
    check_val("async_rst_grant", grant_out, 0);
    check_val("async_rst_timeout", timeout_out, 0);
    check_val("async_rst_busy", busy_out, 0);
    #10;
    rst_n_in = 1'b1;
    presc    = 0;
`ifdef MOTOR_WATCHDOG_EN
    repeat (4) wait_tick();
    check_val("idle_wd_t4", timeout_out, 0);
    wait_tick();
    check_val("idle_wd_t5", timeout_out, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/motor_cmd_arbiter.md
Name: motor_cmd_arbiter

Overview:
- Sits upstream of the DC motor PWM driver and drives its signed 8-bit speed_left/speed_right inputs.
- Arbitrates motion commands from two requesters:
  - port 0: manual/remote, high priority
  - port 1: autonomous planner
- Slew-limits speed changes so the motors never see step changes.
- Applies an e-stop and a command-timeout watchdog that ramps the robot to a stop when commands go stale.

Parameters:
- RAMP_DIV, 98304, clk cycles per ramp tick (1 ms at 98.304 MHz).
- RAMP_STEP, 4, max per-tick change of each speed, 1..127.
- TIMEOUT_TICKS, 250, ticks without an accepted command before the watchdog forces target 0.
- LOCKOUT_TICKS, 500, ticks port 1 stays blocked after a port 0 accept.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  async reset, active low
- estop_in  in  1  emergency stop, level, synchronous use
- req0_valid  in  1  port 0 command valid
- req0_left  in  8  port 0 left target, signed
- req0_right  in  8  port 0 right target, signed
- req0_ready  out  1  port 0 accept
- req1_valid  in  1  port 1 command valid
- req1_left  in  8  port 1 left target, signed
- req1_right  in  8  port 1 right target, signed
- req1_ready  out  1  port 1 accept
- speed_left  out  8  signed, registered, to motor driver
- speed_right  out  8  signed, registered, to motor driver
- grant_out  out  1  source of last accepted command (0/1)
- busy_out  out  1  high while in RAMP
- timeout_out  out  1  watchdog fired, sticky until next accept

Behaviour:
- Reset (async, rst_n_in low):
  - speeds and targets 0; all counters 0; state IDLE.
  - grant_out=0, timeout_out=0, lockout inactive.
- Ready signals: combinational from registered state and current valids.
  - req0_ready = !estop_in && state!=ESTOP.
  - req1_ready = req0_ready && !req0_valid && !lockout.
  - An accept is valid&&ready in the same cycle.
  - Simultaneous valids: port 0 wins; port 1 sees ready low.
- Accept:
  - Target registers load the inputs on the next edge; -128 is clamped to -127.
  - grant_out updates; watchdog counter clears; timeout_out clears.
  - A port 0 accept reloads the lockout counter to LOCKOUT_TICKS.
- Prescaler:
  - Free-running 0..RAMP_DIV-1; tick is asserted for one cycle at the wrap.
  - Accepts never reset it.
- Ramp, on each tick, per side independently:
  - diff = target - speed, computed in 9-bit signed.
  - If |diff| <= RAMP_STEP, speed = target; otherwise speed moves RAMP_STEP toward target.
  - The step uses the target registered before that cycle; a target accepted on a tick cycle affects the next tick.
- Lockout: decrements on each tick while nonzero; lockout = (count != 0).
- Watchdog:
  - Increments on each tick; saturates at TIMEOUT_TICKS.
  - On reaching TIMEOUT_TICKS: targets forced to 0 and timeout_out set.
  - The speed then ramps down normally.
  - An accept in the same cycle wins: the count clears and the new target loads.
- States:
  - IDLE: speeds==0 and targets==0. Leaves to RAMP when target != speed.
  - RAMP: speed != target on either side. Goes to HOLD when both match with a nonzero target, or to IDLE when both are 0.
  - HOLD: matched and nonzero. Goes to RAMP on a target change (accept or watchdog).
  - ESTOP:
    - Entered from any state the cycle after estop_in=1; speeds and targets are forced to 0 on that edge, with no ramp.
    - Readies are low; lockout and watchdog are cleared.
    - Exits to IDLE the cycle after estop_in falls.
- Reset mid-ramp: outputs drop to 0 immediately (async).

Optional Feature:
- Macro: MOTOR_WATCHDOG_EN.
- Defined: watchdog behaves as above.
- Undefined:
  - Watchdog counter not built; timeout_out tied 0.
  - Targets are held indefinitely until the next accept or e-stop.

Test Plan:
Run with RAMP_DIV=4, RAMP_STEP=4, TIMEOUT_TICKS=5, LOCKOUT_TICKS=3.
- Port 1 sends (10,-10) from IDLE -> speeds go (4,-4), (8,-8), (10,-10) on successive ticks; busy_out high during the ramp, then low; state HOLD.
- Both ports valid in the same cycle, port 0 (20,20) and port 1 (-20,-20) -> req1_ready=0; target (20,20); grant_out=0. Port 1 is refused for 3 ticks, then accepted.
- No commands for 5 ticks after HOLD at (8,8) -> timeout_out=1; speeds ramp (4,4), (0,0) to IDLE. The next accept clears timeout_out.
- estop_in pulsed while at (40,-40) -> both speeds 0 on the next edge; req0_ready=req1_ready=0 while asserted; IDLE after release.
- Command -128 on port 0 -> target clamps to -127; the ramp reaches -127 without overflow.
- rst_n_in low mid-ramp, without waiting for a clock edge -> speeds 0, grant_out 0, timeout_out 0. Repeat with MOTOR_WATCHDOG_EN undefined: no timeout after 20 idle ticks.
